// File: rtl/uj_decode_ctrl.sv
// uj_decode_ctrl: U/J-type decode with skid-buffered output, JAL redirect and perf counters.
module imm_extractor (
    input  logic        spec_i,
    input  logic [24:0] data_i,
    output logic [20:0] imm_o
);
    // data_i is instr[31:7]; specifier 1 packs J-type imm[20:1] with duplicated sign at [20]
    assign imm_o = spec_i ? {data_i[24], data_i[24], data_i[12:5], data_i[13], data_i[23:14]}
                          : {data_i[24:5], 1'b0};
endmodule

module uj_decode_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_kind,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] jal_count,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    state_t           state_q, state_d;
    ent_t             or_q, or_d, sk_q, sk_d, new_ent;
    logic             redir_q, redir_d;
    logic [31:0]      rpc_q, rpc_d;
    logic [CNT_W-1:0] jal_q, jal_d, stall_q, stall_d;
    logic [20:0]      e;
    logic [1:0]       kind;
    logic [31:0]      imm;
    logic             accept, issue, jal_iss;

    assign kind = in_instr[6:0] == 7'b0110111 ? 2'b01 :
                  in_instr[6:0] == 7'b0010111 ? 2'b10 :
                  in_instr[6:0] == 7'b1101111 ? 2'b11 : 2'b00;

    imm_extractor u_ext (.spec_i(kind == 2'b11), .data_i(in_instr[31:7]), .imm_o(e));

    assign imm = kind == 2'b00 ? 32'h0 :
                 kind == 2'b11 ? {{11{e[19]}}, e[19:0], 1'b0} : {e[20:1], 12'h000};
    assign new_ent = '{kind: kind, rd: in_instr[11:7], imm: imm, pc: in_pc,
                       tgt: kind == 2'b00 ? 32'h0 : kind == 2'b01 ? imm : in_pc + imm};

    assign in_ready  = state_q != SKID && !redir_q && !rst;
    assign out_valid = state_q != EMPTY;
    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;
    assign jal_iss   = issue && or_q.kind == 2'b11;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        redir_d = 1'b0;
        rpc_d   = rpc_q;
        if (jal_iss) begin
            state_d = EMPTY;
            redir_d = 1'b1;
            rpc_d   = or_q.tgt;
        end else if (state_q == EMPTY && accept) begin
            state_d = FULL;
            or_d    = new_ent;
        end else if (state_q == FULL && accept) begin
            state_d = issue ? FULL : SKID;
            or_d    = issue ? new_ent : or_q;
            sk_d    = issue ? sk_q : new_ent;
        end else if (state_q == FULL && issue) begin
            state_d = EMPTY;
        end else if (state_q == SKID && issue) begin
            state_d = FULL;
            or_d    = sk_q;
        end
        // flush wins over every move above, but the JAL still counts
        if (flush) begin
            state_d = EMPTY;
            redir_d = 1'b0;
        end
        jal_d   = jal_iss && ~&jal_q ? jal_q + 1'b1 : jal_q;
        stall_d = out_valid && !out_ready && ~&stall_q ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            or_q    <= '0;
            sk_q    <= '0;
            redir_q <= 1'b0;
            rpc_q   <= '0;
            jal_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            or_q    <= or_d;
            sk_q    <= sk_d;
            redir_q <= redir_d;
            rpc_q   <= rpc_d;
            jal_q   <= jal_d;
            stall_q <= stall_d;
        end
    end

    assign out_kind       = or_q.kind;
    assign out_rd         = or_q.rd;
    assign out_imm        = or_q.imm;
    assign out_pc         = or_q.pc;
    assign out_target     = or_q.tgt;
    assign redirect_valid = redir_q;
    assign redirect_pc    = rpc_q;
    assign jal_count      = jal_q;
    assign stall_count    = stall_q;
endmodule

// File: tb/tb_uj_decode_ctrl.sv
// tb_uj_decode_ctrl: directed vectors with hand-computed expectations for uj_decode_ctrl.
module tb_uj_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_kind;
    logic [4:0]  out_rd;
    logic [31:0] out_imm, out_pc, out_target, redirect_pc;
    logic        redirect_valid;
    logic [15:0] jal_count, stall_count;
    int          n_chk = 0;
    int          n_err = 0;

    uj_decode_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_kind(out_kind), .out_rd(out_rd), .out_imm(out_imm),
        .out_pc(out_pc), .out_target(out_target), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .jal_count(jal_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_imm", out_imm, 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk("rst jal_count", 32'(jal_count), 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 1);

        send(32'h123452B7, 32'h0);
        cyc();
        in_valid = 1'b0;
        chk("lui valid", 32'(out_valid), 1);
        chk("lui kind", 32'(out_kind), 1);
        chk("lui rd", 32'(out_rd), 5);
        chk("lui imm", out_imm, 32'h12345000);
        chk("lui tgt", out_target, 32'h12345000);
        cyc();
        chk("lui drained", 32'(out_valid), 0);
        chk("lui no redirect", 32'(redirect_valid), 0);

        send(32'h00001517, 32'h200);
        cyc();
        in_valid = 1'b0;
        chk("auipc kind", 32'(out_kind), 2);
        chk("auipc rd", 32'(out_rd), 10);
        chk("auipc imm", out_imm, 32'h00001000);
        chk("auipc tgt", out_target, 32'h00001200);
        chk("auipc pc", out_pc, 32'h200);
        cyc();

        send(32'h008000EF, 32'h100);
        cyc();
        in_valid = 1'b0;
        chk("jal1 kind", 32'(out_kind), 3);
        chk("jal1 rd", 32'(out_rd), 1);
        chk("jal1 imm", out_imm, 32'h8);
        chk("jal1 tgt", out_target, 32'h108);
        cyc();
        chk("jal1 redirect", 32'(redirect_valid), 1);
        chk("jal1 redirect_pc", redirect_pc, 32'h108);
        chk("jal1 in_ready", 32'(in_ready), 0);
        cyc();
        chk("jal1 redirect end", 32'(redirect_valid), 0);
        chk("jal1 in_ready back", 32'(in_ready), 1);
        send(32'hFFDFF06F, 32'h40);
        cyc();
        in_valid = 1'b0;
        chk("jal2 rd", 32'(out_rd), 0);
        chk("jal2 imm", out_imm, 32'hFFFFFFFC);
        cyc();
        chk("jal2 redirect_pc", redirect_pc, 32'h3C);
        chk("jal_count 2", 32'(jal_count), 2);
        cyc();

        out_ready = 1'b0;
        send(32'h000010B7, 32'h0);
        cyc();
        chk("bp full in_ready", 32'(in_ready), 1);
        send(32'h00002137, 32'h4);
        cyc();
        send(32'h000031B7, 32'h8);
        chk("bp skid in_ready", 32'(in_ready), 0);
        chk("bp head imm", out_imm, 32'h1000);
        chk("bp stall 1", 32'(stall_count), 1);
        cyc();
        chk("bp hold rd", 32'(out_rd), 1);
        chk("bp hold imm", out_imm, 32'h1000);
        chk("bp stall 2", 32'(stall_count), 2);
        out_ready = 1'b1;
        cyc();
        chk("bp second imm", out_imm, 32'h2000);
        chk("bp second rd", 32'(out_rd), 2);
        chk("bp in_ready again", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        chk("bp third imm", out_imm, 32'h3000);
        chk("bp stall held", 32'(stall_count), 2);
        cyc();
        chk("bp drained", 32'(out_valid), 0);

        out_ready = 1'b0;
        send(32'h008000EF, 32'h100);
        cyc();
        send(32'h00001517, 32'h200);
        cyc();
        in_valid = 1'b0;
        chk("js head kind", 32'(out_kind), 3);
        out_ready = 1'b1;
        cyc();
        chk("js redirect", 32'(redirect_valid), 1);
        chk("js redirect_pc", redirect_pc, 32'h108);
        chk("js out_valid", 32'(out_valid), 0);
        cyc();
        chk("js auipc dropped", 32'(out_valid), 0);
        chk("js in_ready", 32'(in_ready), 1);
        chk("js jal_count", 32'(jal_count), 3);
        chk("js stall", 32'(stall_count), 3);

        out_ready = 1'b0;
        send(32'h000010B7, 32'h0);
        cyc();
        send(32'h00002137, 32'h4);
        cyc();
        send(32'h000031B7, 32'h8);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl skid out_valid", 32'(out_valid), 0);
        chk("fl skid in_ready", 32'(in_ready), 1);
        chk("fl stall", 32'(stall_count), 5);
        send(32'h000010B7, 32'h0);
        cyc();
        send(32'h00002137, 32'h4);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl full out_valid", 32'(out_valid), 0);
        cyc();
        chk("fl stays empty", 32'(out_valid), 0);
        chk("fl stall 6", 32'(stall_count), 6);

        send(32'h000010B7, 32'h0);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("pre-rst stall", 32'(stall_count), 7);
        #2 rst = 1'b1;
        #1;
        chk("arst out_valid", 32'(out_valid), 0);
        chk("arst out_imm", out_imm, 0);
        chk("arst out_kind", 32'(out_kind), 0);
        chk("arst stall", 32'(stall_count), 0);
        chk("arst jal", 32'(jal_count), 0);
        chk("arst in_ready", 32'(in_ready), 0);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("arst release in_ready", 32'(in_ready), 1);
        chk("arst release out_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
